// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Select codes, NZCV flag bit positions and requester id type
//            shared by the ALU arbiter and its clients.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    // Bit positions inside the {N,Z,C,V} flag register
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // 0 = execute stage, 1 = address/branch-offset unit
    typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_if
// Purpose  : Request/response bundle between the two ALU clients and the
//            shared-ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SELW  = 3
);

    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [1:0][WIDTH-1:0]       req_a;
    logic [1:0][WIDTH-1:0]       req_b;
    logic [1:0][SELW-1:0]        req_sel;
    logic [1:0]                  req_setf;
    logic [1:0]                  rsp_valid;
    logic [1:0]                  rsp_ready;
    logic [1:0][WIDTH-1:0]       rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_sel, req_setf, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, req_setf, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter; one-hot grant, remembers the last
//            winner so a tie goes to the other requester.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import alu_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_eligible,
    output logic      [1:0] o_grant,
    output req_id_t         o_grant_id
);

    req_id_t r_last_grant;

    always_comb begin
        o_grant = 2'b00;
        unique case (i_eligible)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_last_grant == 1'b1) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
        o_grant_id = o_grant[1];
    end

    // Starts at 1 so requester 0 wins the first tie after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (|o_grant) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational ALU between two requesters, registers
//            each result into a per-requester slot and owns the NZCV flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned SELW  = 3
) (
    input  wire logic              clk,
    input  wire logic              reset,
    alu_share_arbiter_if.slave     bus,
    output logic      [WIDTH-1:0]  alu_a,
    output logic      [WIDTH-1:0]  alu_b,
    output logic      [SELW-1:0]   alu_sel,
    input  wire logic [WIDTH-1:0]  alu_result,
    input  wire logic              alu_n,
    input  wire logic              alu_z,
    input  wire logic              alu_v,
    input  wire logic              alu_c,
    output logic      [3:0]        flags
);

    logic [1:0]            w_eligible;
    logic [1:0]            w_grant;
    req_id_t               w_grant_id;
    logic [3:0]            w_flags_new;
    logic [1:0]            r_rsp_valid;
    logic [1:0][WIDTH-1:0] r_rsp_result;
    logic [3:0]            r_flags;

    // A full slot can take a new result in the same cycle it is drained;
    // nothing is accepted while reset is held so no request leaks through it.
    assign w_eligible = {2{~reset}} & bus.req_valid & (~r_rsp_valid | bus.rsp_ready);

    rr_arb2 u_arb (
        .clk        (clk),
        .rst        (reset),
        .i_eligible (w_eligible),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign bus.req_ready = w_grant;

    // Grant id is 0 when idle, so requester 0 drives the ALU by default
    assign alu_a   = bus.req_a[w_grant_id];
    assign alu_b   = bus.req_b[w_grant_id];
    assign alu_sel = bus.req_sel[w_grant_id];

    always_comb begin
        w_flags_new         = 4'b0000;
        w_flags_new[FLAG_N] = alu_n;
        w_flags_new[FLAG_Z] = alu_z;
        w_flags_new[FLAG_C] = alu_c;
        w_flags_new[FLAG_V] = alu_v;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_grant[i]) begin
                    r_rsp_valid[i]  <= 1'b1;
                    r_rsp_result[i] <= alu_result;
                end else if (r_rsp_valid[i] && bus.rsp_ready[i]) begin
                    r_rsp_valid[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if ((|w_grant) && bus.req_setf[w_grant_id]) begin
            r_flags <= w_flags_new;
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign flags          = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench: vector table, corner sequences and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int unsigned W = 64;

    typedef struct packed {
        logic [63:0] res;
        logic        n, z, c, v;
    } alu_out_t;

    typedef struct {
        logic        id;
        logic [2:0]  sel;
        logic [63:0] a, b;
        logic        setf;
        logic [63:0] exp_res;
        logic [3:0]  exp_flags;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [63:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    logic        alu_n, alu_z, alu_v, alu_c;
    logic [3:0]  flags;
    alu_out_t    alu_o;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arbiter_if #(.WIDTH(W), .SELW(3)) bus ();

    alu_share_arbiter #(.WIDTH(W), .SELW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .alu_c      (alu_c),
        .flags      (flags)
    );

    // The shared ALU itself; unlisted selects return an arbitrary mix
    function automatic alu_out_t alu_ref(input logic [2:0] sel, input logic [63:0] a, input logic [63:0] b);
        alu_out_t    o;
        logic [64:0] wide;
        o = '0;
        case (sel)
            ALU_PASSB: o.res = b;
            ALU_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                o.res = wide[63:0];
                o.c   = wide[64];
                o.v   = (a[63] == b[63]) && (o.res[63] != a[63]);
            end
            ALU_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                o.res = wide[63:0];
                o.c   = ~wide[64];
                o.v   = (a[63] != b[63]) && (o.res[63] != a[63]);
            end
            ALU_AND: o.res = a & b;
            ALU_OR:  o.res = a | b;
            ALU_XOR: o.res = a ^ b;
            default: o.res = a ^ ~b;
        endcase
        o.n = o.res[63];
        o.z = (o.res == 64'd0);
        return o;
    endfunction

    function automatic logic [3:0] nzcv(input alu_out_t o);
        return {o.n, o.z, o.c, o.v};
    endfunction

    always_comb alu_o = alu_ref(alu_sel, alu_a, alu_b);
    assign alu_result = alu_o.res;
    assign alu_n = alu_o.n;
    assign alu_z = alu_o.z;
    assign alu_c = alu_o.c;
    assign alu_v = alu_o.v;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.req_setf  = 2'b00;
    endtask

    task automatic set_req(input logic id, input logic [2:0] sel, input logic [63:0] a,
                           input logic [63:0] b, input logic setf);
        bus.req_valid[id] = 1'b1;
        bus.req_sel[id]   = sel;
        bus.req_a[id]     = a;
        bus.req_b[id]     = b;
        bus.req_setf[id]  = setf;
    endtask

    vec_t        vecs[11];
    logic [1:0]  exp_g;
    logic [63:0] exp_r;
    logic [63:0] rnd_a, rnd_b;

    // Reference model state for the randomized run
    logic [1:0]       m_valid;
    logic [1:0][63:0] m_res;
    logic [3:0]       m_flags;
    logic             m_last;
    logic [1:0]       m_elig;
    logic             gid;

    initial begin
        vecs[0]  = '{1'b0, ALU_AND, 64'hFF00FF00FF00FF00, 64'h0F0F0F0F0F0F0F0F, 1'b1, 64'h0F000F000F000F00, 4'b0000};
        vecs[1]  = '{1'b1, ALU_SUB, 64'd5, 64'd5, 1'b1, 64'd0, 4'b0110};
        vecs[2]  = '{1'b0, ALU_ADD, 64'd1, 64'd2, 1'b0, 64'd3, 4'b0110};
        vecs[3]  = '{1'b0, ALU_AND, 64'h8000000000000000, 64'h8000000000000000, 1'b1, 64'h8000000000000000, 4'b1000};
        vecs[4]  = '{1'b1, ALU_AND, 64'd0, 64'h1234, 1'b1, 64'd0, 4'b0100};
        vecs[5]  = '{1'b0, ALU_ADD, 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b1, 64'd0, 4'b0110};
        vecs[6]  = '{1'b1, ALU_ADD, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b1, 64'h8000000000000000, 4'b1001};
        vecs[7]  = '{1'b0, ALU_SUB, 64'd0, 64'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 4'b1000};
        vecs[8]  = '{1'b1, ALU_OR, 64'hF0, 64'h0F, 1'b1, 64'hFF, 4'b0000};
        vecs[9]  = '{1'b0, ALU_XOR, 64'hFF, 64'h0F, 1'b0, 64'hF0, 4'b0000};
        vecs[10] = '{1'b1, ALU_PASSB, 64'd1, 64'hDEAD, 1'b1, 64'hDEAD, 4'b0000};

        idle_inputs();
        bus.rsp_ready = 2'b00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_result0", bus.rsp_result[0], 64'd0);
        chk("reset_rsp_result1", bus.rsp_result[1], 64'd0);
        chk("reset_flags", 64'(flags), 64'd0);

        // Single operations, consumer always ready
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 11; k++) begin
            idle_inputs();
            set_req(vecs[k].id, vecs[k].sel, vecs[k].a, vecs[k].b, vecs[k].setf);
            #1;
            chk($sformatf("vec%0d_ready", k), 64'(bus.req_ready), vecs[k].id ? 64'd2 : 64'd1);
            @(negedge clk);
            idle_inputs();
            chk($sformatf("vec%0d_rsp_valid", k), 64'(bus.rsp_valid[vecs[k].id]), 64'd1);
            chk($sformatf("vec%0d_result", k), bus.rsp_result[vecs[k].id], vecs[k].exp_res);
            chk($sformatf("vec%0d_flags", k), 64'(flags), 64'(vecs[k].exp_flags));
        end

        // Both always valid: grants alternate, last winner was requester 1
        exp_g = 2'b01;
        for (int k = 0; k < 8; k++) begin
            rnd_a = {$urandom, $urandom};
            rnd_b = {$urandom, $urandom};
            set_req(1'b0, ALU_ADD, rnd_a, rnd_b, 1'b0);
            set_req(1'b1, ALU_XOR, rnd_b, rnd_a, 1'b0);
            exp_r = exp_g[1] ? (rnd_b ^ rnd_a) : (rnd_a + rnd_b);
            #1;
            chk($sformatf("alt%0d_ready", k), 64'(bus.req_ready), 64'(exp_g));
            @(negedge clk);
            chk($sformatf("alt%0d_rsp_valid", k), 64'(bus.rsp_valid), 64'(exp_g));
            chk($sformatf("alt%0d_result", k), bus.rsp_result[exp_g[1]], exp_r);
            exp_g = ~exp_g;
        end
        idle_inputs();
        @(negedge clk);

        // Backpressure on requester 0 with a full slot
        bus.rsp_ready = 2'b00;
        set_req(1'b0, ALU_SUB, 64'd5, 64'd5, 1'b1);
        #1;
        chk("bp_first_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        set_req(1'b1, ALU_OR, 64'h10, 64'h01, 1'b0);
        set_req(1'b0, ALU_ADD, 64'd100, 64'd23, 1'b0);
        #1;
        chk("bp_blocked_ready", 64'(bus.req_ready), 64'd2);
        @(negedge clk);
        chk("bp_both_full", 64'(bus.rsp_valid), 64'd3);
        chk("bp_r0_held", bus.rsp_result[0], 64'd0);
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready = 2'b01;
        #1;
        chk("bp_reaccept_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        chk("bp_reaccept_valid", 64'(bus.rsp_valid), 64'd3);
        chk("bp_reaccept_result", bus.rsp_result[0], 64'd123);
        chk("bp_r1_result", bus.rsp_result[1], 64'h11);
        chk("bp_flags", 64'(flags), 64'h6);

        // Reset with both slots full and requests pending
        bus.rsp_ready = 2'b00;
        set_req(1'b0, ALU_SUB, 64'd0, 64'd1, 1'b1);
        set_req(1'b1, ALU_ADD, 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrst_flags", 64'(flags), 64'd0);
        chk("midrst_result0", bus.rsp_result[0], 64'd0);
        bus.rsp_ready = 2'b11;
        #1;
        chk("midrst_first_tie", 64'(bus.req_ready), 64'd1);
        @(negedge clk);

        // Randomized run against the reference model, from a clean reset
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_valid = 2'b00;
        m_res   = '0;
        m_flags = 4'b0000;
        m_last  = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            chk("rnd_rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
            chk("rnd_result0", bus.rsp_result[0], m_res[0]);
            chk("rnd_result1", bus.rsp_result[1], m_res[1]);
            chk("rnd_flags", 64'(flags), 64'(m_flags));

            reset = ($urandom_range(0, 63) == 0);
            bus.req_valid = 2'($urandom);
            bus.rsp_ready = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                bus.req_a[i] = {$urandom, $urandom};
                bus.req_b[i] = ($urandom_range(0, 3) == 0) ? bus.req_a[i] : {$urandom, $urandom};
                bus.req_sel[i] = 3'($urandom_range(0, 7));
                bus.req_setf[i] = 1'($urandom);
            end
            #1;
            if (reset) begin
                m_valid = 2'b00;
                m_res   = '0;
                m_flags = 4'b0000;
                m_last  = 1'b1;
            end else begin
                m_elig = bus.req_valid & (~m_valid | bus.rsp_ready);
                if (m_elig == 2'b11) exp_g = m_last ? 2'b01 : 2'b10;
                else                 exp_g = m_elig;
                chk("rnd_ready", 64'(bus.req_ready), 64'(exp_g));
                gid = exp_g[1];
                if (exp_g != 2'b00) begin
                    chk("rnd_alu_a", alu_a, bus.req_a[gid]);
                    chk("rnd_alu_b", alu_b, bus.req_b[gid]);
                end
                for (int i = 0; i < 2; i++) begin
                    if (exp_g[i]) begin
                        m_valid[i] = 1'b1;
                        m_res[i]   = alu_ref(bus.req_sel[i], bus.req_a[i], bus.req_b[i]).res;
                    end else if (m_valid[i] && bus.rsp_ready[i]) begin
                        m_valid[i] = 1'b0;
                    end
                end
                if (exp_g != 2'b00) begin
                    if (bus.req_setf[gid])
                        m_flags = nzcv(alu_ref(bus.req_sel[gid], bus.req_a[gid], bus.req_b[gid]));
                    m_last = gid;
                end
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
